imem_loader: RTL

//  Byte-stream writer for the instruction memory. Receives a length-prefixed, checksummed program image

---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input and instruction-memory write port bundle
//               for the instruction memory loader.
//   in_valid   stream byte present on in_data
//   in_data    8-bit stream byte
//   in_ready   loader accepts byte (transfer when in_valid & in_ready)
//   mem_we     1-cycle word write strobe
//   mem_addr   4-aligned byte address of the written word
//   mem_wdata  little-endian 32-bit word
// Modports    : slave  = loader side, master = host / memory side
// Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a length-prefixed, XOR-checksummed program image
//               over a valid/ready byte stream, assembles little-endian
//               32-bit words and writes them to instruction memory at byte
//               addresses 0,4,8,...  Keeps the processor held in reset until
//               the image is complete and its checksum verified.
// Ports       :
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      1-cycle pulse, begins a load from IDLE / DONE / ERR
//   bus        imem_loader_if.slave (byte stream in, memory write port out)
//   cpu_hold   1 = processor held in reset
//   done       image loaded and checksum good (level)
//   error      load aborted on bad length or checksum (level)
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 1024
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              in_ready;
  logic              xfer;
  logic [15:0]       len;
  logic [15:0]       len_full;
  logic [1:0]        byte_idx;
  logic [15:0]       word_idx;
  logic [23:0]       word_lo;
  logic [7:0]        chk;
  logic              last_word;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  assign xfer      = bus.in_valid & in_ready;
  // Length as it will be once the high byte currently on the bus is latched.
  assign len_full  = {bus.in_data, len[7:0]};
  assign last_word = (word_idx + 16'd1) == len;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LEN0;
      S_LEN0:  if (xfer) state_next = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (len_full == 16'd0 || len_full > MAX_LEN) state_next = S_ERR;
          else                                         state_next = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_idx == 2'd3 && last_word) state_next = S_CHK;
      S_CHK:   if (xfer) state_next = (bus.in_data == chk) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_next = S_LEN0;
      S_ERR:   if (start) state_next = S_LEN0;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  // Status is decoded from the state register, so it moves the cycle after
  // the deciding transfer.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_LEN0, S_LEN1, S_DATA, S_CHK: in_ready = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= 16'd0;
      byte_idx  <= 2'd0;
      word_idx  <= 16'd0;
      word_lo   <= 24'd0;
      chk       <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        len      <= 16'd0;
        byte_idx <= 2'd0;
        word_idx <= 16'd0;
        word_lo  <= 24'd0;
        chk      <= 8'd0;
      end
      if (xfer) begin
        case (state)
          S_LEN0: len[7:0]  <= bus.in_data;
          S_LEN1: len[15:8] <= bus.in_data;
          S_DATA: begin
            chk      <= chk ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_lo[7:0]   <= bus.in_data;
              2'd1:    word_lo[15:8]  <= bus.in_data;
              2'd2:    word_lo[23:16] <= bus.in_data;
              default: begin
                // Fourth byte completes the word; it goes straight to the
                // write register rather than through word_lo.
                mem_we    <= 1'b1;
                mem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                mem_wdata <= {bus.in_data, word_lo};
                word_idx  <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule
`default_nettype wire
